// File: rtl/mac_ram_sequencer.sv
`timescale 1ns/1ps
// mac_ram_sequencer
// Walks a list of operand pairs in a dual-port synchronous RAM, feeds each
// pair to an external accumulating MAC and writes the low half of the
// running result back through RAM port B.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   start, len              : job request (one cycle) and pair count
//   src_base, dst_base      : operand and result start addresses
//   addr_a/addr_b, we_a/we_b, data_in_b, data_out_a/data_out_b : RAM side
//   mac_a, mac_b, valid_in, mac_reset, result, valid_out       : MAC side
//   busy, done, error       : status (done is a pulse, error is sticky)
module mac_ram_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   len,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]   addr_b,
    output logic                we_a,
    output logic                we_b,
    output logic [DATA_W-1:0]   data_in_b,
    input  logic [DATA_W-1:0]   data_out_a,
    input  logic [DATA_W-1:0]   data_out_b,
    output logic [DATA_W-1:0]   mac_a,
    output logic [DATA_W-1:0]   mac_b,
    output logic                valid_in,
    output logic                mac_reset,
    input  logic [2*DATA_W-1:0] result,
    input  logic                valid_out,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, CLR, RD_ADDR, RD_WAIT, ISSUE, WAIT_MAC, WRITE, GAP, FIN
    } state_t;

    state_t              state, nxt;
    logic [ADDR_W-1:0]   i, len_q, src_q, dst_q;
    logic [TW-1:0]       tcnt;
    logic [DATA_W-1:0]   res_q;
    logic                timed_out;

    // Only the low half of the accumulator is stored back to RAM.
    logic unused_result_hi;
    assign unused_result_hi = ^result[2*DATA_W-1:DATA_W];

    assign timed_out = (tcnt == TW'(TIMEOUT - 1)) && !valid_out;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (start) nxt = (len == '0) ? FIN : CLR;
            CLR:      nxt = RD_ADDR;
            RD_ADDR:  nxt = RD_WAIT;
            RD_WAIT:  nxt = ISSUE;
            ISSUE:    nxt = WAIT_MAC;
            WAIT_MAC: if (valid_out) nxt = WRITE;
                      else if (timed_out) nxt = FIN;
            WRITE:    nxt = GAP;
            GAP:      nxt = (ADDR_W'(i + 1'b1) == len_q) ? FIN : RD_ADDR;
            FIN:      nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            i     <= '0;
            len_q <= '0;
            src_q <= '0;
            dst_q <= '0;
            tcnt  <= '0;
            res_q <= '0;
            mac_a <= '0;
            mac_b <= '0;
            error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    len_q <= len;
                    src_q <= src_base;
                    dst_q <= dst_base;
                    i     <= '0;
                    error <= 1'b0;
                end
                // RAM data is valid at the second edge after the address, so
                // the operands are captured leaving RD_WAIT and presented
                // together with valid_in during ISSUE.
                RD_WAIT: begin
                    mac_a <= data_out_a;
                    mac_b <= data_out_b;
                end
                ISSUE: tcnt <= '0;
                WAIT_MAC: begin
                    tcnt <= tcnt + 1'b1;
                    if (valid_out)      res_q <= result[DATA_W-1:0];
                    else if (timed_out) error <= 1'b1;
                end
                GAP: i <= i + 1'b1;
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        mac_reset = (state == CLR);
        valid_in  = (state == ISSUE);
        we_a      = 1'b0;
        we_b      = (state == WRITE);
        addr_a    = '0;
        addr_b    = '0;
        data_in_b = '0;
        if (state == RD_ADDR || state == RD_WAIT) begin
            addr_a = src_q + i;
            addr_b = src_q + i;
        end else if (state == WRITE) begin
            addr_b    = dst_q + i;
            data_in_b = res_q;
        end
    end
endmodule

// File: tb/tb_mac_ram_sequencer.sv
`timescale 1ns/1ps
module tb_mac_ram_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  len = '0, src_base = '0, dst_base = '0;
    logic [4:0]  addr_a, addr_b;
    logic        we_a, we_b;
    logic [15:0] data_in_b, data_out_a, data_out_b;
    logic [15:0] mac_a, mac_b;
    logic        valid_in, mac_reset, valid_out;
    logic [31:0] result;
    logic        busy, done, error;

    always #5 clk = ~clk;

    mac_ram_sequencer #(.ADDR_W(5), .DATA_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .src_base(src_base), .dst_base(dst_base),
        .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a), .we_b(we_b),
        .data_in_b(data_in_b), .data_out_a(data_out_a), .data_out_b(data_out_b),
        .mac_a(mac_a), .mac_b(mac_b), .valid_in(valid_in), .mac_reset(mac_reset),
        .result(result), .valid_out(valid_out),
        .busy(busy), .done(done), .error(error)
    );

    // Dual-port synchronous RAM: port A reads ram_a, port B reads/writes ram_b.
    logic [15:0] ram_a [0:31];
    logic [15:0] ram_b [0:31];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;
    logic [4:0]  wlog [0:63];
    int          wcnt = 0, vcnt = 0, dcnt = 0, mcnt = 0, acnt = 0;

    always @(posedge clk) begin
        data_out_a <= ram_a[addr_a];
        data_out_b <= ram_b[addr_b];
        if (we_b) begin
            ram_b[addr_b]    <= data_in_b;
            wlog[wcnt[5:0]]  <= addr_b;
            wcnt             <= wcnt + 1;
        end else if (tb_we) begin
            ram_b[tb_addr] <= tb_data;
        end
        if (valid_in)  vcnt <= vcnt + 1;
        if (done)      dcnt <= dcnt + 1;
        if (mac_reset) mcnt <= mcnt + 1;
        if (we_a)      acnt <= acnt + 1;
    end

    // Accumulating MAC, one-cycle latency; mac_dead suppresses valid_out.
    logic        mac_dead = 1'b0;
    logic [31:0] acc = '0;
    assign result = acc;
    always @(posedge clk) begin
        valid_out <= 1'b0;
        if (mac_reset) acc <= '0;
        else if (valid_in) begin
            acc       <= acc + mac_a * mac_b;
            valid_out <= !mac_dead;
        end
    end

    int total = 0, bad = 0;
    int v0, d0, m0, w0, cyc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {busy, done, error, we_a, we_b, valid_in, mac_reset,
                  addr_a, addr_b, data_in_b, mac_a, mac_b}, '0);
    endtask

    task automatic poke_b(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk); tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk); tb_we = 1'b0;
    endtask

    task automatic snap();
        v0 = vcnt; d0 = dcnt; m0 = mcnt; w0 = wcnt;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!done && c < 400) begin @(negedge clk); c++; end
        chk("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic run(input logic [4:0] l, input logic [4:0] s, input logic [4:0] d, output int c);
        @(negedge clk); len = l; src_base = s; dst_base = d; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(c);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ram_a[k] = 16'h0;
        ram_a[0] = 4; ram_a[1] = 5; ram_a[2] = 6; ram_a[3] = 7;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        reset = 1'b0;
        poke_b(0, 3); poke_b(1, 3); poke_b(2, 2); poke_b(3, 1);
        for (int k = 16; k < 20; k++) poke_b(5'(k), 16'hFFFF);

        // Four pairs, accumulating
        snap();
        run(4, 0, 16, cyc);
        chk("acc_r16", ram_b[16], 12);
        chk("acc_r17", ram_b[17], 27);
        chk("acc_r18", ram_b[18], 39);
        chk("acc_r19", ram_b[19], 46);
        chk("acc_valid_in", vcnt - v0, 4);
        chk("acc_done", dcnt - d0, 1);
        chk("acc_mac_reset", mcnt - m0, 1);
        chk("acc_busy_idle", busy, 1'b0);

        // len = 0
        snap();
        run(0, 5, 6, cyc);
        chk("len0_latency", cyc <= 2, 1'b1);
        chk("len0_we_b", wcnt - w0, 0);
        chk("len0_valid_in", vcnt - v0, 0);
        chk("len0_mac_reset", mcnt - m0, 0);
        chk("len0_done", dcnt - d0, 1);

        // Wrapped, overlapping ranges: later reads must see earlier writes
        ram_a[30] = 2; ram_a[31] = 3; ram_a[0] = 1;
        poke_b(30, 5); poke_b(31, 7); poke_b(0, 9); poke_b(1, 0);
        snap();
        run(3, 30, 31, cyc);
        chk("wrap_r31", ram_b[31], 10);
        chk("wrap_r0", ram_b[0], 40);
        chk("wrap_r1", ram_b[1], 80);
        chk("wrap_waddr", {wlog[w0[5:0]], wlog[6'(w0 + 1)], wlog[6'(w0 + 2)]},
            {5'd31, 5'd0, 5'd1});

        // MAC never answers
        mac_dead = 1'b1;
        poke_b(20, 16'hAAAA);
        snap();
        run(2, 0, 20, cyc);
        chk("to_error", error, 1'b1);
        chk("to_cycles", cyc, 21);
        chk("to_no_write", wcnt - w0, 0);
        chk("to_ram", ram_b[20], 16'hAAAA);
        chk("to_done", dcnt - d0, 1);
        chk("to_busy", busy, 1'b0);
        mac_dead = 1'b0;

        // Reset during WAIT_MAC of pair 2
        ram_a[0] = 4;
        poke_b(0, 3); poke_b(1, 3); poke_b(24, 0); poke_b(25, 16'h5555);
        snap();
        @(negedge clk); len = 3; src_base = 0; dst_base = 24; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(valid_in && vcnt == v0 + 1) && cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst_reach_pair2", valid_in, 1'b1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid_outputs");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_r24", ram_b[24], 12);
        chk("rst_r25", ram_b[25], 16'h5555);
        chk("rst_writes", wcnt - w0, 1);
        poke_b(28, 0);
        run(1, 1, 28, cyc);
        chk("rst_rerun_r28", ram_b[28], 15);
        chk("rst_rerun_error", error, 1'b0);

        // start re-pulsed while busy must be ignored
        poke_b(8, 0); poke_b(9, 0); poke_b(12, 16'h1234);
        snap();
        @(negedge clk); len = 2; src_base = 2; dst_base = 8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        len = 5; src_base = 10; dst_base = 12; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(cyc);
        chk("restart_r8", ram_b[8], 12);
        chk("restart_r9", ram_b[9], 19);
        chk("restart_r12", ram_b[12], 16'h1234);
        chk("restart_valid_in", vcnt - v0, 2);
        chk("restart_done", dcnt - d0, 1);
        chk("we_a_never", acnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_ram_sequencer.md
MAC_RAM_SEQUENCER -- requirements
Module: mac_ram_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_W, default 5, RAM address width; DATA_W, default 16, operand width; TIMEOUT, default 16, max cycles waiting for MAC valid_out.
REQ-002 SHALL have ports: clk, input, 1, sole clock, all logic on rising edge.
REQ-003 SHALL have ports: reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports: start, input, 1, single-cycle job request.
REQ-005 SHALL have ports: len, input, ADDR_W, number of operand pairs to process (0..31).
REQ-006 SHALL have ports: src_base, input, ADDR_W; dst_base, input, ADDR_W; operand start address and result start address.
REQ-007 SHALL have ports: addr_a, addr_b, output, ADDR_W each; we_a, we_b, output, 1 each; data_in_b, output, DATA_W; data_out_a, data_out_b, input, DATA_W. These are the dual-port RAM connections.
REQ-008 SHALL have ports: mac_a, mac_b, output, DATA_W; valid_in, output, 1; mac_reset, output, 1; result, input, 2*DATA_W; valid_out, input, 1. These are the mac_unit connections.
REQ-009 SHALL have ports: busy, output, 1; done, output, 1 (one-cycle pulse); error, output, 1 (sticky until next start).

Function
REQ-010 SHALL latch len, src_base and dst_base on an accepted start; start SHALL be accepted only in IDLE and ignored otherwise.
REQ-011 SHALL implement states IDLE -> CLR -> RD_ADDR -> RD_WAIT -> ISSUE -> WAIT_MAC -> WRITE -> GAP -> (RD_ADDR | FIN) -> IDLE.
REQ-012 CLR SHALL assert mac_reset for exactly one cycle.
REQ-013 RD_ADDR SHALL drive addr_a = addr_b = src_base+i.
REQ-014 RD_WAIT SHALL hold the address; RAM data SHALL be treated as valid on the second rising edge after the address was presented.
REQ-015 ISSUE SHALL register mac_a<=data_out_a and mac_b<=data_out_b, and SHALL assert valid_in for exactly one cycle.
REQ-016 WAIT_MAC SHALL wait for valid_out=1 and SHALL then capture result in the following cycle.
REQ-017 WRITE SHALL assert we_b for one cycle with addr_b = dst_base+i and data_in_b = result[DATA_W-1:0].
REQ-018 GAP SHALL increment i; the FSM SHALL go to FIN when i==len, else to RD_ADDR.
REQ-019 FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-020 we_a SHALL be held 0 at all times; the block SHALL never write through port A.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W; src and dst wrap from 31 to 0.
REQ-022 len=0: after start the block SHALL go directly to FIN, pulse done, and perform no RAM or MAC activity, including no mac_reset.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 If valid_out is not seen within TIMEOUT cycles in WAIT_MAC, the block SHALL set error, skip the write, and go to FIN.
REQ-025 A valid_out outside WAIT_MAC SHALL be ignored.
REQ-026 Overlapping src and dst ranges SHALL be processed in strict order; later reads SHALL see earlier writes.

Reset
REQ-027 reset SHALL force IDLE and i=0, with all outputs 0: busy, done, error, we_a, we_b, valid_in, mac_reset, addresses, data_in_b, mac_a and mac_b.
REQ-028 reset mid-job SHALL abort the job in the same edge with no further RAM write; reset has priority over start.

Verification
REQ-029 RAM[0..3]: a={4,5,6,7}, b={3,3,2,1}; start, len=4, src=0, dst=16. Required: RAM[16..19]={12,27,39,46} with an accumulating MAC; exactly 4 valid_in pulses and one done pulse.
REQ-030 len=0 start. Required: done within 2 cycles; we_b, valid_in and mac_reset never asserted.
REQ-031 src=30, dst=31, len=3. Required: reads at 30, 31, 0 and writes at 31, 0, 1, the latter honoring REQ-026.
REQ-032 MAC model never asserts valid_out. Required: error=1 after TIMEOUT cycles, no write, done pulses, busy falls.
REQ-033 reset asserted during WAIT_MAC of pair 2. Required: next cycle all outputs 0, no write to dst+1; a subsequent start runs normally.
REQ-034 start re-pulsed while busy. Required: ignored; the original job completes with unchanged len and bases.
